// File: rtl/trip_control.sv
// trip_control: run/pause/clear controller for the trip timing block.
// Turns button edges and wheel activity into timing enable/reset controls.
module trip_control #(
    parameter int unsigned AUTO_PAUSE_SEC = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       wheel_pulse,
    input  logic       sec_pulse,
    input  logic       half_sec_pulse,
    output logic       timing_enable,
    output logic       timing_reset,
    output logic [1:0] run_state,
    output logic       blink
);

    typedef enum logic [1:0] {
        STOPPED     = 2'b00,
        RUNNING     = 2'b01,
        PAUSED      = 2'b10,
        AUTO_PAUSED = 2'b11
    } state_t;

    localparam logic [3:0] IDLE_LAST = 4'(AUTO_PAUSE_SEC - 1);

    state_t     state;
    state_t     state_next;
    logic       start_prev;
    logic       clear_prev;
    logic       start_edge;
    logic       clear_edge;
    logic       clear_accept;
    logic       idle_expired;
    logic [3:0] idle_cnt;

    assign start_edge   = btn_start & ~start_prev;
    assign clear_edge   = btn_clear & ~clear_prev;
    assign idle_expired = sec_pulse & ~wheel_pulse & (idle_cnt == IDLE_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= STOPPED;
            start_prev <= 1'b0;
            clear_prev <= 1'b0;
        end else begin
            state      <= state_next;
            start_prev <= btn_start;
            clear_prev <= btn_clear;
        end
    end

    always_comb begin
        state_next   = state;
        clear_accept = 1'b0;
        unique case (state)
            STOPPED: begin
                if (clear_edge) begin
                    clear_accept = 1'b1;
                end else if (start_edge) begin
                    state_next = RUNNING;
                end
            end
            RUNNING: begin
                if (start_edge) begin
                    state_next = PAUSED;
                end else if (idle_expired) begin
                    state_next = AUTO_PAUSED;
                end
            end
            PAUSED: begin
                if (clear_edge) begin
                    clear_accept = 1'b1;
                    state_next   = STOPPED;
                end else if (start_edge) begin
                    state_next = RUNNING;
                end
            end
            AUTO_PAUSED: begin
                if (start_edge) begin
                    state_next = PAUSED;
                end else if (wheel_pulse) begin
                    state_next = RUNNING;
                end
            end
            default: state_next = STOPPED;
        endcase
    end

    always_comb begin
        timing_enable = (state == RUNNING);
        run_state     = state;
    end

    // Counter is held at zero outside RUNNING, so every entry starts fresh.
    always_ff @(posedge clock) begin
        if (reset) begin
            idle_cnt <= 4'd0;
        end else if (state != RUNNING || wheel_pulse) begin
            idle_cnt <= 4'd0;
        end else if (sec_pulse) begin
            idle_cnt <= idle_cnt + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timing_reset <= 1'b0;
        end else begin
            timing_reset <= clear_accept;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            blink <= 1'b0;
        end else if (state_next != state) begin
            blink <= 1'b0;
        end else if (state == PAUSED || state == AUTO_PAUSED) begin
            if (half_sec_pulse) begin
                blink <= ~blink;
            end
        end else begin
            blink <= 1'b0;
        end
    end

endmodule

// File: tb/tb_trip_control.sv
// tb_trip_control: scoreboard bench for trip_control with a
// behavioural trip model, directed scenarios and random stimulus.
module tb_trip_control;

    localparam int AUTO = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       btn_start;
    logic       btn_clear;
    logic       wheel_pulse;
    logic       sec_pulse;
    logic       half_sec_pulse;
    logic       timing_enable;
    logic       timing_reset;
    logic [1:0] run_state;
    logic       blink;

    trip_control #(.AUTO_PAUSE_SEC(AUTO)) dut (
        .clock          (clock),
        .reset          (reset),
        .btn_start      (btn_start),
        .btn_clear      (btn_clear),
        .wheel_pulse    (wheel_pulse),
        .sec_pulse      (sec_pulse),
        .half_sec_pulse (half_sec_pulse),
        .timing_enable  (timing_enable),
        .timing_reset   (timing_reset),
        .run_state      (run_state),
        .blink          (blink)
    );

    always #5 clock = ~clock;

    // expected {run_state, timing_enable, timing_reset, blink}
    logic [4:0] exp_q[$];
    string      tag_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    string      phase = "init";

    // Reference model: mode names and seconds-since-wheel count
    int m_mode;   // 0 stopped, 1 running, 2 paused, 3 auto-paused
    int m_secs;
    bit m_blink;
    bit m_clr;
    bit m_ps;
    bit m_pc;

    task automatic model(input bit r, s, c, w, sp, hp);
        bit se, ce;
        int nxt;
        if (r) begin
            m_mode = 0; m_secs = 0; m_blink = 0;
            m_clr = 0; m_ps = 0; m_pc = 0;
            return;
        end
        se = s && !m_ps;
        ce = c && !m_pc;
        m_ps = s;
        m_pc = c;
        nxt = m_mode;
        m_clr = 0;
        case (m_mode)
            0: if (ce) m_clr = 1; else if (se) nxt = 1;
            1: begin
                if (se) nxt = 2;
                else if (w) m_secs = 0;
                else if (sp) begin
                    m_secs = m_secs + 1;
                    if (m_secs >= AUTO) nxt = 3;
                end
            end
            2: if (ce) begin m_clr = 1; nxt = 0; end
               else if (se) nxt = 1;
            default: if (se) nxt = 2; else if (w) nxt = 1;
        endcase
        if (nxt != m_mode) m_blink = 0;
        else if (m_mode >= 2 && hp) m_blink = !m_blink;
        if (nxt == 1 && m_mode != 1) m_secs = 0;
        m_mode = nxt;
    endtask

    task automatic step(input bit r, s, c, w, sp, hp);
        logic [1:0] st;
        @(negedge clock);
        reset = r; btn_start = s; btn_clear = c;
        wheel_pulse = w; sec_pulse = sp; half_sec_pulse = hp;
        model(r, s, c, w, sp, hp);
        st = 2'(m_mode);
        exp_q.push_back({st, m_mode == 1, m_clr, m_blink});
        tag_q.push_back(phase);
    endtask

    // Monitor: every clock the DUT presents a full output set
    always @(posedge clock) begin
        logic [4:0] e;
        logic [4:0] a;
        string t;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {run_state, timing_enable, timing_reset, blink};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s t=%0t actual st=%b en=%b tr=%b bl=%b required st=%b en=%b tr=%b bl=%b",
                         t, $time, a[4:3], a[2], a[1], a[0], e[4:3], e[2], e[1], e[0]);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic secs(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, 0, 1, 0);
            step(0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        bit s, c, w, sp, hp, r;
        int wrate;
        reset = 1; btn_start = 0; btn_clear = 0;
        wheel_pulse = 0; sec_pulse = 0; half_sec_pulse = 0;

        phase = "reset";
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(2);

        phase = "start_hold";
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        idle(2);

        phase = "auto_pause";
        secs(AUTO);
        idle(2);
        phase = "wheel_resume";
        step(0, 0, 0, 1, 0, 0);
        idle(2);

        phase = "wheel_with_sec";
        secs(AUTO - 1);
        step(0, 0, 0, 1, 1, 0);
        secs(AUTO - 1);
        idle(1);
        secs(1);
        idle(1);
        step(0, 0, 0, 1, 0, 0);

        phase = "pause_blink";
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 1);
            idle(1);
        end
        phase = "pause_clear";
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        idle(1);

        phase = "stopped_both";
        step(0, 1, 1, 0, 0, 0);
        idle(2);
        phase = "running_clear";
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        idle(2);

        phase = "reset_in_auto";
        secs(AUTO);
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        idle(3);
        step(0, 1, 0, 0, 0, 0);
        idle(2);

        phase = "random";
        s = 0; c = 0; wrate = 4;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) wrate = $urandom_range(0, 2) * 8;
            if ($urandom_range(0, 9) == 0) s = !s;
            if ($urandom_range(0, 11) == 0) c = !c;
            w  = (wrate != 0) && ($urandom_range(0, wrate - 1) == 0);
            sp = ($urandom_range(0, 5) == 0);
            hp = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 699) == 0);
            step(r, s, c, w, sp, hp);
        end
        idle(3);

        @(posedge clock);
        #3;
        phase = "drain";
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain actual %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trip_control.md
# trip_control

Run/pause/clear controller for the trip timing block. Converts the rider's start/stop and clear buttons, plus wheel activity, into the timing block's `enable` and `reset` controls. It implements manual pause and auto-pause when the wheel stops turning. It also drives a blink flag that the display uses while the trip is paused. It sits between the button conditioning logic and the timing counter in the bike-computer datapath.

## Interface
- `AUTO_PAUSE_SEC`, default 4: whole seconds without a wheel pulse before RUNNING auto-pauses; legal range 1..15.
- `clock`  in  1  system clock; single clock domain; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge.
- `btn_start`  in  1  start/stop button level; already synchronized and debounced.
- `btn_clear`  in  1  clear button level; already synchronized and debounced.
- `wheel_pulse`  in  1  one-cycle pulse per wheel revolution.
- `sec_pulse`  in  1  one-cycle 1 Hz pulse from the timing block.
- `half_sec_pulse`  in  1  one-cycle 2 Hz pulse from the timing block.
- `timing_enable`  out  1  enable to the timing block.
- `timing_reset`  out  1  one-cycle clear pulse to the timing block.
- `run_state`  out  2  current state: 00 STOPPED, 01 RUNNING, 10 PAUSED, 11 AUTO_PAUSED.
- `blink`  out  1  display blink phase while paused.

## Operation
- Button edges:
  - Each button has a registered previous-value flop.
  - An edge is `btn & ~btn_prev`. An edge fires once per press, however long the button is held.
  - The previous-value flops clear to 0 on reset.
- STOPPED (the reset state):
  - Start edge -> RUNNING.
  - Clear edge -> `timing_reset` pulse; state stays STOPPED.
  - If both edges arrive together, clear wins and the state stays STOPPED.
- RUNNING:
  - Start edge -> PAUSED.
  - Clear edge is ignored.
  - Idle counter (4 bits):
    - Cleared on any `wheel_pulse` and on every entry into RUNNING.
    - Incremented on `sec_pulse`.
    - If `sec_pulse` arrives with counter == `AUTO_PAUSE_SEC`-1 and there is no `wheel_pulse` that cycle -> AUTO_PAUSED.
    - `wheel_pulse` and `sec_pulse` in the same cycle: the counter clears and no transition occurs.
  - A start edge takes priority over auto-pause in the same cycle (-> PAUSED).
- PAUSED:
  - Start edge -> RUNNING.
  - Clear edge -> `timing_reset` pulse and -> STOPPED.
  - If both edges arrive together, clear wins.
  - `wheel_pulse` is ignored.
- AUTO_PAUSED:
  - `wheel_pulse` -> RUNNING.
  - Start edge -> PAUSED. A start edge together with `wheel_pulse` also goes to PAUSED.
  - Clear edge is ignored.
- `timing_enable` = (state == RUNNING), decoded from the state register with no extra flop.
- `blink`:
  - Cleared to 0 on every state change.
  - Toggles on each `half_sec_pulse` while in PAUSED or AUTO_PAUSED.
  - Held at 0 in STOPPED and RUNNING.
- `timing_reset` is a registered pulse, exactly one cycle wide per accepted clear.
- `reset` mid-operation:
  - Next edge: state STOPPED, idle counter 0, `blink` 0, `timing_reset` 0.
  - No `timing_reset` pulse is generated by `reset` itself; the timing block receives the global reset directly.

## Timing
- Reset values: `timing_enable`=0, `timing_reset`=0, `run_state`=00, `blink`=0.
- Start edge sampled at edge N -> `run_state`/`timing_enable` change after edge N+1. Latency is one clock from the first cycle the button is high.
- Clear edge sampled at edge N -> `timing_reset` high for the cycle after edge N+1. The state update to STOPPED happens on the same edge.
- Auto-pause: `timing_enable` drops one clock after the qualifying `sec_pulse`. That is `AUTO_PAUSE_SEC` seconds (±1 s phase) after the last wheel pulse.
- Resume from AUTO_PAUSED: `timing_enable` rises one clock after `wheel_pulse`.
- `blink` toggles one clock after each qualifying `half_sec_pulse`.

## Test plan
- Apply reset, then raise `btn_start` for 3 cycles -> exactly one transition; `run_state`=01 and `timing_enable`=1 from the second cycle on.
- In RUNNING with no wheel pulses and 4 `sec_pulse` (default parameter) -> `run_state`=11 and `timing_enable`=0 one clock after the 4th. A `wheel_pulse` then -> `run_state`=01.
- In RUNNING, `wheel_pulse` coincides with the 4th `sec_pulse` -> stays 01 and the counter restarts. A further 4 `sec_pulse` with no wheel -> 11.
- RUNNING -> start edge -> PAUSED (10). Then 3 `half_sec_pulse` -> `blink` sequence 1,0,1. Then a clear edge -> `timing_reset` high for exactly 1 cycle, `run_state`=00, `blink`=0.
- In STOPPED, start and clear edges in the same cycle -> one `timing_reset` pulse and `run_state` stays 00. In RUNNING, a clear edge -> no `timing_reset` and `run_state` stays 01.
- Assert `reset` while in AUTO_PAUSED with `blink`=1 -> next cycle all outputs are at their reset values. A following start edge is needed to run again.
